// File: rtl/mux4_rr_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mux4_arb_pkg: shared types, sizes and round-robin pick function.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package mux4_arb_pkg;

  localparam int NREQ  = 4;
  localparam int IDX_W = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Rotate so req[last+1] lands on bit 0, take the lowest set bit, undo the rotation.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0]  req,
                                               input logic [IDX_W-1:0] last);
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [IDX_W-1:0]  off;
    dbl = {req, req};
    rot = dbl[(int'(last) + 1) +: NREQ];
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    return last + off + IDX_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux4_rr_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mux4_rr_arbiter_if: requester side and output stream of the mux. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface mux4_rr_arbiter_if
  import mux4_arb_pkg::*;
#(
  parameter int DW = 4
);
  logic [NREQ-1:0]  req;
  logic [DW-1:0]    data_a;
  logic [DW-1:0]    data_b;
  logic [DW-1:0]    data_c;
  logic [DW-1:0]    data_d;
  logic [NREQ-1:0]  gnt;
  logic [IDX_W-1:0] sel;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic             out_ready;

  modport slave (
    input  req, data_a, data_b, data_c, data_d, out_ready,
    output gnt, sel, out_valid, out_data
  );

  modport master (
    output req, data_a, data_b, data_c, data_d, out_ready,
    input  gnt, sel, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/mux4_rr_arbiter_rr_pick.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mux4_arb_rr_pick: combinational round-robin rotate + encode.     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mux4_arb_rr_pick
  import mux4_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] pick,
  output logic             any
);
  assign any  = |req;
  assign pick = rr_pick(req, last);
endmodule
`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mux4_rr_arbiter: round-robin owner select for a shared 4:1 mux.   |
// | Optional burst cap: define MUX4_ARB_BURST_LIMIT_EN.               |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int DW        = 4,
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mux4_rr_arbiter_if.slave  bus
);

  state_e           r_state, w_state_nxt;
  logic [NREQ-1:0]  r_gnt,   w_gnt_nxt;
  logic [IDX_W-1:0] r_sel,   w_sel_nxt;
  logic [IDX_W-1:0] r_last,  w_last_nxt;

  logic [IDX_W-1:0] w_pick;
  logic             w_any;
  logic             w_valid;
  logic             w_release;
  logic             w_burst_end;
  logic [DW-1:0]    w_data;

  mux4_arb_rr_pick u_pick (
    .req  (bus.req),
    .last (r_last),
    .pick (w_pick),
    .any  (w_any)
  );

  assign w_valid = |(r_gnt & bus.req);

`ifdef MUX4_ARB_BURST_LIMIT_EN
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_xfer;

  assign w_xfer      = w_valid & bus.out_ready;
  assign w_burst_end = w_xfer && (r_cnt == CNT_W'(MAX_BURST - 1));

  // Held at zero while idle, so every grant starts counting from zero.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (r_state == IDLE) begin
      w_cnt_nxt = '0;
    end else if (w_xfer) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= w_cnt_nxt;
  end
`else
  logic w_unused_cfg;
  assign w_burst_end  = 1'b0;
  assign w_unused_cfg = bus.out_ready ^ (MAX_BURST != CNT_W);
`endif

  assign w_release = (r_state == GRANT) && (!bus.req[r_sel] || w_burst_end);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_last  <= IDX_W'(NREQ - 1);
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any)     w_state_nxt = GRANT;
      GRANT:   if (w_release) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; release always passes through IDLE.
  always_comb begin
    w_gnt_nxt  = r_gnt;
    w_sel_nxt  = r_sel;
    w_last_nxt = r_last;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_sel_nxt = w_pick;
          w_gnt_nxt = NREQ'(1) << w_pick;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_gnt_nxt  = '0;
          w_sel_nxt  = '0;
          w_last_nxt = r_sel;
        end
      end
      default: begin
        w_gnt_nxt = '0;
        w_sel_nxt = '0;
      end
    endcase
  end

  always_comb begin
    w_data = '0;
    if (|r_gnt) begin
      case (r_sel)
        2'd0:    w_data = bus.data_a;
        2'd1:    w_data = bus.data_b;
        2'd2:    w_data = bus.data_c;
        default: w_data = bus.data_d;
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.sel       = r_sel;
  assign bus.out_valid = w_valid;
  assign bus.out_data  = w_data;

endmodule
`default_nettype wire
